burst_ram_arbiter: RTL and testbench
====================================

# burst_ram_arbiter

Two-port arbiter that shares one BurstRAM between the instruction cache (port 0) and the data cache (port 1). It grants whole bursts, one at a time, and forwards the owner's command, write beats and mask to the RAM. It returns read beats to the owner only. It sits between the two Cache instances and the single BurstRAM, all in the RAM clock domain.

## Interface
- ADDRESS_BITWIDTH, 8, BurstRAM address width (burst-aligned word address)
- DATA_BITWIDTH, 64, BurstRAM beat width; mask width is DATA_BITWIDTH/8
- BURST_COUNT, 4, beats per burst (power of two, ≥2)

Ports:
- clk  in  1  RAM clock
- rst  in  1  asynchronous active-high reset
- rN_req  in  1  request from port N (N=0,1); level, held until granted
- rN_cmd  in  1  0 = read, 1 = write
- rN_addr  in  ADDRESS_BITWIDTH  burst address
- rN_wr_data  in  DATA_BITWIDTH  write beat (beat 0 valid with req)
- rN_data_mask  in  DATA_BITWIDTH/8  byte mask per beat
- rN_gnt  out  1  one-cycle grant; beat 0 is accepted this cycle
- rN_rd_data  out  DATA_BITWIDTH  br_rd_data broadcast
- rN_rd_data_valid  out  1  br_rd_data_valid gated to the owner
- rN_busy  out  1  high while port N's burst is in flight
- br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask  out  BurstRAM command side
- br_rd_data, br_rd_data_valid, br_busy  in  BurstRAM response side

## Operation
- States: IDLE, WRITE, READ. Registers: state, owner (1 bit), beat counter ($clog2(BURST_COUNT) bits), last_winner (round-robin only).
- IDLE with br_busy=0 and any req: pick a winner. rgnt[winner]=1 and br_cmd_en=1 in that same cycle. br_cmd, br_addr, wr_data and mask come from the winner. Owner is latched, counter is cleared, and state goes to WRITE or READ per the winner's cmd.
- IDLE with br_busy=1: no grant. br_cmd_en=0.
- WRITE: the owner presents beats 1..BURST_COUNT-1 on consecutive cycles. The arbiter forwards the owner's wr_data and mask combinationally. The counter increments per cycle. After beat BURST_COUNT-1 is forwarded, state goes to IDLE.
- READ: each br_rd_data_valid increments the counter and pulses rN_rd_data_valid for the owner. On beat BURST_COUNT-1, state goes to IDLE.
- br_rd_data_valid outside READ is ignored and never forwarded.
- rN_busy = (state≠IDLE && owner==N).
- Dropping req before grant is legal and has no effect. Req must not be raised by the current owner until its busy falls.
- Counter wraps naturally at BURST_COUNT; no extra compare width.

## Timing
- Reset values: state IDLE, owner 0, counter 0, last_winner 1. All gnt, rd_data_valid, busy and br_cmd_en are 0. br_cmd, br_addr, br_wr_data and br_data_mask are 0.
- Grant is combinational from registered state. Grant latency is 0 cycles from req in an idle, non-busy cycle.
- Back-to-back bursts: at least one IDLE cycle after the last beat before the next grant.
- Simultaneous requests: exactly one grant; the loser keeps req high and is granted in the next eligible IDLE cycle.
- Reset mid-burst: immediate return to IDLE and the burst is abandoned. BurstRAM shares rst, so no stale beats are expected; any that arrive are dropped.

## Configuration
- BURST_RAM_ARBITER_ROUND_ROBIN_EN defined: on contention the port that did not win last gets the grant. last_winner updates on every grant.
- Undefined: fixed priority, port 1 (data) beats port 0. last_winner logic is not compiled.

## Structure
- Package burst_ram_arbiter_pkg holds:
  - state enum (IDLE/WRITE/READ)
  - CMD_READ=0 and CMD_WRITE=1 constants
  - port index constants PORT_I=0 and PORT_D=1
- One sub-module: burst_ram_arbiter_pick. It is combinational winner selection from req[1:0], last_winner and the macro.

## Test plan
Bench conditions: BurstRAM with CYCLES_BEFORE_DATA_READY=3, BURST_COUNT=4, RAM.mem.

- Port 0 read at addr 0 only: r0_gnt in the request cycle; four r0_rd_data_valid beats, the first with low word 0xB7C6A980; r1_rd_data_valid stays 0.
- Both ports request reads at addr 0 and 16 in the same cycle, fixed priority: r1_gnt first. r0_gnt comes exactly in the first IDLE cycle after r1's fourth beat.
- Same as above with ROUND_ROBIN_EN and last grant to port 1: port 0 wins, then port 1.
- Port 1 write at addr 8, beats 0x1111…, 0x2222…, 0x3333…, 0x4444…, mask 0xFF: br_wr_data carries those values on 4 consecutive cycles. A port 0 read of addr 8 afterwards returns the same four beats.
- br_busy held high while both req are asserted: no gnt and br_cmd_en=0. Release br_busy: grant occurs the same cycle.
- rst asserted on the second read beat: all outputs go to reset values asynchronously. After release a new port 0 request is granted normally.

Source files
------------

// File: rtl/burst_ram_arbiter_pkg.sv
// burst_ram_arbiter_pkg: shared state encoding, command and port constants for the BurstRAM arbiter
package burst_ram_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;
    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;
    localparam int   PORT_I    = 0;
    localparam int   PORT_D    = 1;
endpackage

// File: rtl/burst_ram_arbiter_pick.sv
// burst_ram_arbiter_pick: combinational winner select; BURST_RAM_ARBITER_ROUND_ROBIN_EN picks
// the port that did not win last on contention, otherwise the data port has fixed priority.
module burst_ram_arbiter_pick
    import burst_ram_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       winner_o
);
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
    assign winner_o = (req_i[PORT_I] && req_i[PORT_D]) ? ~last_i : req_i[PORT_D];
`else
    logic unused_last;
    assign unused_last = last_i;
    assign winner_o    = req_i[PORT_D];
`endif
endmodule

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: grants whole BurstRAM bursts to the I-cache (port 0) or D-cache (port 1).
// Define BURST_RAM_ARBITER_ROUND_ROBIN_EN for round-robin contention instead of fixed D-priority.
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH = 8,
    parameter int DATA_BITWIDTH    = 64,
    parameter int BURST_COUNT      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         r0_req,
    input  logic                         r0_cmd,
    input  logic [ADDRESS_BITWIDTH-1:0]  r0_addr,
    input  logic [DATA_BITWIDTH-1:0]     r0_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]   r0_data_mask,
    output logic                         r0_gnt,
    output logic [DATA_BITWIDTH-1:0]     r0_rd_data,
    output logic                         r0_rd_data_valid,
    output logic                         r0_busy,
    input  logic                         r1_req,
    input  logic                         r1_cmd,
    input  logic [ADDRESS_BITWIDTH-1:0]  r1_addr,
    input  logic [DATA_BITWIDTH-1:0]     r1_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]   r1_data_mask,
    output logic                         r1_gnt,
    output logic [DATA_BITWIDTH-1:0]     r1_rd_data,
    output logic                         r1_rd_data_valid,
    output logic                         r1_busy,
    output logic                         br_cmd,
    output logic                         br_cmd_en,
    output logic [ADDRESS_BITWIDTH-1:0]  br_addr,
    output logic [DATA_BITWIDTH-1:0]     br_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]   br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]     br_rd_data,
    input  logic                         br_rd_data_valid,
    input  logic                         br_busy
);
    localparam int CW = $clog2(BURST_COUNT);
    state_e state_q, state_d;
    logic owner_q, owner_d, winner, last, grant, sel, sel_cmd, fwd, rd_ok;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0] req;
    logic [ADDRESS_BITWIDTH-1:0] sel_addr;
    logic [DATA_BITWIDTH-1:0] sel_wd;
    logic [DATA_BITWIDTH/8-1:0] sel_mask;

    assign req = {r1_req, r0_req};
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
    logic last_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) last_q <= 1'b1;
        else if (grant) last_q <= winner;
    assign last = last_q;
`else
    assign last = 1'b1;
`endif

    burst_ram_arbiter_pick u_pick (.req_i(req), .last_i(last), .winner_o(winner));

    // rst gates the grant so every output sits at its reset value while reset is held
    assign grant    = !rst && state_q == IDLE && !br_busy && |req;
    assign sel      = (state_q == IDLE) ? winner : owner_q;
    assign sel_cmd  = sel ? r1_cmd : r0_cmd;
    assign sel_addr = sel ? r1_addr : r0_addr;
    assign sel_wd   = sel ? r1_wr_data : r0_wr_data;
    assign sel_mask = sel ? r1_data_mask : r0_data_mask;
    assign rd_ok    = state_q == READ && br_rd_data_valid;
    assign cnt_inc  = cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end

    // WRITE forwards beat cnt_q+1, so the burst ends once cnt_inc reaches the last beat
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (grant) begin
            state_d = (sel_cmd == CMD_WRITE) ? WRITE : READ;
            owner_d = winner;
            cnt_d   = '0;
        end else if (state_q == WRITE) begin
            cnt_d   = cnt_inc;
            state_d = (&cnt_inc) ? IDLE : WRITE;
        end else if (rd_ok) begin
            cnt_d   = cnt_inc;
            state_d = (&cnt_q) ? IDLE : READ;
        end
    end

    always_comb begin
        fwd              = grant || state_q == WRITE;
        br_cmd_en        = grant;
        br_cmd           = grant ? sel_cmd : 1'b0;
        br_addr          = grant ? sel_addr : '0;
        br_wr_data       = fwd ? sel_wd : '0;
        br_data_mask     = fwd ? sel_mask : '0;
        r0_gnt           = grant && !winner;
        r1_gnt           = grant && winner;
        r0_rd_data       = br_rd_data;
        r1_rd_data       = br_rd_data;
        r0_rd_data_valid = rd_ok && !owner_q;
        r1_rd_data_valid = rd_ok && owner_q;
        r0_busy          = state_q != IDLE && !owner_q;
        r1_busy          = state_q != IDLE && owner_q;
    end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: directed bench with a behavioural BurstRAM (read latency 3, 4-beat bursts)
module tb_burst_ram_arbiter;
    logic clk, rst;
    logic r0_req, r0_cmd, r1_req, r1_cmd;
    logic [7:0] r0_addr, r1_addr, br_addr;
    logic [63:0] r0_wr_data, r1_wr_data, r0_rd_data, r1_rd_data, br_wr_data, br_rd_data;
    logic [7:0] r0_data_mask, r1_data_mask, br_data_mask;
    logic r0_gnt, r1_gnt, r0_rd_data_valid, r1_rd_data_valid, r0_busy, r1_busy;
    logic br_cmd, br_cmd_en, br_rd_data_valid, br_busy, busy_force;
    int errors = 0;
    int checks = 0;
    int n_beats;
    logic other_seen;
    logic [63:0] beats [4];

`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
    localparam bit FIRST = 1'b0;
`else
    localparam bit FIRST = 1'b1;
`endif

    burst_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_cmd(r0_cmd), .r0_addr(r0_addr), .r0_wr_data(r0_wr_data),
        .r0_data_mask(r0_data_mask), .r0_gnt(r0_gnt), .r0_rd_data(r0_rd_data),
        .r0_rd_data_valid(r0_rd_data_valid), .r0_busy(r0_busy),
        .r1_req(r1_req), .r1_cmd(r1_cmd), .r1_addr(r1_addr), .r1_wr_data(r1_wr_data),
        .r1_data_mask(r1_data_mask), .r1_gnt(r1_gnt), .r1_rd_data(r1_rd_data),
        .r1_rd_data_valid(r1_rd_data_valid), .r1_busy(r1_busy),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
        .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_word(input int i);
        return {32'(i), 32'hB7C6A980 + 32'(i)};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // BurstRAM model: ph 0 idle, 1 latency wait, 2 read beats, 3 write beats 1..3
    logic [63:0] mem [256];
    logic [1:0] ph, wt, bt;
    logic [7:0] ra;
    assign br_busy = (ph != 2'd0) || busy_force;
    always @(posedge clk or posedge rst)
        if (rst) begin
            ph <= 0; wt <= 0; bt <= 0; ra <= 0;
            br_rd_data_valid <= 0; br_rd_data <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= exp_word(i);
        end else begin
            br_rd_data_valid <= 0;
            case (ph)
                2'd0: if (br_cmd_en) begin
                    ra <= br_addr;
                    bt <= br_cmd ? 2'd1 : 2'd0;
                    if (br_cmd) begin
                        mem[br_addr] <= merge(mem[br_addr], br_wr_data, br_data_mask);
                        ph <= 3;
                    end else begin
                        ph <= 1; wt <= 1;
                    end
                end
                2'd1: if (wt == 0) ph <= 2; else wt <= wt - 1;
                2'd2: begin
                    br_rd_data_valid <= 1;
                    br_rd_data <= mem[8'(ra + bt)];
                    bt <= bt + 1;
                    if (bt == 3) ph <= 0;
                end
                default: begin
                    mem[8'(ra + bt)] <= merge(mem[8'(ra + bt)], br_wr_data, br_data_mask);
                    bt <= bt + 1;
                    if (bt == 3) ph <= 0;
                end
            endcase
        end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        rst = 1; tick; rst = 0; tick;
    endtask

    // records port p's read beats; returns in the cycle after the fourth beat
    task automatic collect(input bit p);
        n_beats = 0; other_seen = 0;
        for (int c = 0; c < 40 && n_beats < 4; c++) begin
            if (p ? r0_rd_data_valid : r1_rd_data_valid) other_seen = 1;
            if (p ? r1_rd_data_valid : r0_rd_data_valid) begin
                beats[n_beats] = p ? r1_rd_data : r0_rd_data;
                n_beats++;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst = 1; r0_req = 1; r1_req = 1; r0_addr = 8'h55; r1_addr = 8'h66;
        r0_wr_data = '1; r1_wr_data = '1; r0_data_mask = '1; r1_data_mask = '1;
        #2;
        checks++; if ({r1_gnt, r0_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", {r1_gnt, r0_gnt}); end
        checks++; if (br_cmd_en !== 1'b0) begin errors++; $display("FAIL reset_cmd_en got=%b exp=0", br_cmd_en); end
        checks++; if ({br_cmd, br_addr} !== 9'h0) begin errors++; $display("FAIL reset_cmd_addr got=%h exp=0", {br_cmd, br_addr}); end
        checks++; if ({br_wr_data, br_data_mask} !== 72'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", {br_wr_data, br_data_mask}); end
        checks++; if ({r1_busy, r0_busy, r1_rd_data_valid, r0_rd_data_valid} !== 4'h0) begin errors++; $display("FAIL reset_busy_valid got=%b exp=0000", {r1_busy, r0_busy, r1_rd_data_valid, r0_rd_data_valid}); end
        r0_req = 0; r1_req = 0;
        tick; tick; rst = 0; tick;
    endtask

    task automatic test_read_p0;
        r0_cmd = 0; r0_addr = 0; r0_req = 1; #1;
        checks++; if ({r1_gnt, r0_gnt, br_cmd_en} !== 3'b011) begin errors++; $display("FAIL rd_gnt got=%b exp=011", {r1_gnt, r0_gnt, br_cmd_en}); end
        checks++; if ({br_cmd, br_addr} !== 9'h000) begin errors++; $display("FAIL rd_cmd_addr got=%h exp=000", {br_cmd, br_addr}); end
        tick; r0_req = 0;
        checks++; if ({r1_busy, r0_busy} !== 2'b01) begin errors++; $display("FAIL rd_busy got=%b exp=01", {r1_busy, r0_busy}); end
        collect(0);
        checks++; if (n_beats !== 4) begin errors++; $display("FAIL rd_nbeats got=%0d exp=4", n_beats); end
        checks++; if (beats[0][31:0] !== 32'hB7C6A980) begin errors++; $display("FAIL rd_beat0_low got=%h exp=b7c6a980", beats[0][31:0]); end
        checks++; if (beats[3] !== exp_word(3)) begin errors++; $display("FAIL rd_beat3 got=%h exp=%h", beats[3], exp_word(3)); end
        checks++; if (other_seen !== 1'b0) begin errors++; $display("FAIL rd_r1_valid got=%b exp=0", other_seen); end
        checks++; if (r0_busy !== 1'b0) begin errors++; $display("FAIL rd_busy_end got=%b exp=0", r0_busy); end
    endtask

    task automatic test_contention;
        logic [7:0] fa, la;
        do_reset;
        fa = FIRST ? 8'd16 : 8'd0;
        la = FIRST ? 8'd0 : 8'd16;
        r0_cmd = 0; r0_addr = 0; r1_cmd = 0; r1_addr = 16; r0_req = 1; r1_req = 1; #1;
        checks++; if ({r1_gnt, r0_gnt} !== (FIRST ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_first_gnt got=%b first=%0d", {r1_gnt, r0_gnt}, FIRST); end
        checks++; if (br_addr !== fa) begin errors++; $display("FAIL cont_first_addr got=%h exp=%h", br_addr, fa); end
        tick;
        if (FIRST) r1_req = 0; else r0_req = 0;
        collect(FIRST);
        checks++; if (n_beats !== 4) begin errors++; $display("FAIL cont_first_nbeats got=%0d exp=4", n_beats); end
        checks++; if (beats[0] !== exp_word(int'(fa))) begin errors++; $display("FAIL cont_first_beat0 got=%h exp=%h", beats[0], exp_word(int'(fa))); end
        checks++; if (other_seen !== 1'b0) begin errors++; $display("FAIL cont_leak got=%b exp=0", other_seen); end
        checks++; if ({r1_gnt, r0_gnt} !== (FIRST ? 2'b01 : 2'b10)) begin errors++; $display("FAIL cont_second_gnt got=%b first=%0d", {r1_gnt, r0_gnt}, FIRST); end
        checks++; if (br_addr !== la) begin errors++; $display("FAIL cont_second_addr got=%h exp=%h", br_addr, la); end
        tick; r0_req = 0; r1_req = 0;
        collect(!FIRST);
        checks++; if (n_beats !== 4) begin errors++; $display("FAIL cont_second_nbeats got=%0d exp=4", n_beats); end
        checks++; if (beats[3] !== exp_word(int'(la) + 3)) begin errors++; $display("FAIL cont_second_beat3 got=%h exp=%h", beats[3], exp_word(int'(la) + 3)); end
    endtask

    task automatic test_write_readback;
        logic [63:0] pat [4];
        pat[0] = 64'h1111111111111111; pat[1] = 64'h2222222222222222;
        pat[2] = 64'h3333333333333333; pat[3] = 64'h4444444444444444;
        r1_cmd = 1; r1_addr = 8; r1_data_mask = 8'hFF; r1_wr_data = pat[0]; r1_req = 1; #1;
        checks++; if ({r1_gnt, br_cmd_en, br_cmd} !== 3'b111) begin errors++; $display("FAIL wr_gnt got=%b exp=111", {r1_gnt, br_cmd_en, br_cmd}); end
        checks++; if (br_wr_data !== pat[0]) begin errors++; $display("FAIL wr_beat0 got=%h exp=%h", br_wr_data, pat[0]); end
        for (int b = 1; b < 4; b++) begin
            tick; r1_req = 0; r1_wr_data = pat[b]; #1;
            checks++; if (br_wr_data !== pat[b]) begin errors++; $display("FAIL wr_beat%0d got=%h exp=%h", b, br_wr_data, pat[b]); end
            checks++; if ({br_data_mask, br_cmd_en, r1_busy} !== 10'b1111111101) begin errors++; $display("FAIL wr_mask_en_busy%0d got=%b exp=1111111101", b, {br_data_mask, br_cmd_en, r1_busy}); end
        end
        tick;
        checks++; if (r1_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got=%b exp=0", r1_busy); end
        r0_cmd = 0; r0_addr = 8; r0_req = 1; #1;
        checks++; if (r0_gnt !== 1'b1) begin errors++; $display("FAIL wrrd_gnt got=%b exp=1", r0_gnt); end
        tick; r0_req = 0;
        collect(0);
        for (int b = 0; b < 4; b++) begin
            checks++; if (beats[b] !== pat[b]) begin errors++; $display("FAIL wrrd_beat%0d got=%h exp=%h", b, beats[b], pat[b]); end
        end
    endtask

    task automatic test_busy_hold;
        busy_force = 1;
        r0_cmd = 0; r0_addr = 0; r1_cmd = 0; r1_addr = 16; r0_req = 1; r1_req = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({r1_gnt, r0_gnt, br_cmd_en} !== 3'b000) begin errors++; $display("FAIL busy_hold%0d got=%b exp=000", c, {r1_gnt, r0_gnt, br_cmd_en}); end
            tick;
        end
        busy_force = 0; #1;
        checks++; if ({r1_gnt, r0_gnt, br_cmd_en} !== 3'b101) begin errors++; $display("FAIL busy_release got=%b exp=101", {r1_gnt, r0_gnt, br_cmd_en}); end
        tick; r0_req = 0; r1_req = 0;
        collect(1);
        checks++; if (n_beats !== 4) begin errors++; $display("FAIL busy_nbeats got=%0d exp=4", n_beats); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        r0_cmd = 0; r0_addr = 0; r0_req = 1; #1;
        checks++; if (r0_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got=%b exp=1", r0_gnt); end
        tick; r0_req = 0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (r0_rd_data_valid) seen = 1;
            tick;
        end
        checks++; if (r0_rd_data_valid !== 1'b1) begin errors++; $display("FAIL mid_second_beat got=%b exp=1", r0_rd_data_valid); end
        r0_addr = 16; r0_req = 1; rst = 1; #1;
        checks++; if ({r0_rd_data_valid, r0_busy, r0_gnt, br_cmd_en} !== 4'b0000) begin errors++; $display("FAIL mid_rst_out got=%b exp=0000", {r0_rd_data_valid, r0_busy, r0_gnt, br_cmd_en}); end
        checks++; if ({br_addr, br_wr_data} !== 72'h0) begin errors++; $display("FAIL mid_rst_br got=%h exp=0", {br_addr, br_wr_data}); end
        @(posedge clk); #1 rst = 0; #1;
        checks++; if ({r0_gnt, br_cmd_en} !== 2'b11 || br_addr !== 8'd16) begin errors++; $display("FAIL post_rst_gnt got=%b addr=%h exp=11 addr=10", {r0_gnt, br_cmd_en}, br_addr); end
        tick; r0_req = 0;
        collect(0);
        checks++; if (n_beats !== 4 || beats[0] !== exp_word(16)) begin errors++; $display("FAIL post_rst_read got=%0d/%h exp=4/%h", n_beats, beats[0], exp_word(16)); end
    endtask

    initial begin
        clk = 0; rst = 1; busy_force = 0;
        r0_req = 0; r0_cmd = 0; r0_addr = 0; r0_wr_data = 0; r0_data_mask = 0;
        r1_req = 0; r1_cmd = 0; r1_addr = 0; r1_wr_data = 0; r1_data_mask = 0;
        test_reset;
        test_read_p0;
        test_contention;
        test_write_readback;
        test_busy_hold;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
